agen_stage: RTL and testbench
=============================

# agen_stage

Address-generation stage between register access and memory read/execute. Takes each register-access beat (ModR/M, SIB, displacement, segment override, register and segment values), computes the 32-bit effective offset and selects the segment, and registers the result in a 2-entry skid buffer with valid/ready handshakes. Other decoded fields travel unchanged on a parameterised sideband bus.

## Interface
- SIDE_W, 512: width of the opaque sideband bundle (op fields, imm, pc, MMX values, etc.) carried with each beat.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; empties the buffer.
- flush  in  1  synchronous; discards all held beats and any beat offered this cycle.
- r_valid  in  1  upstream beat valid.
- r_ready  out  1  stage can accept a beat (registered).
- r_modrm  in  8  ModR/M byte.
- r_sib  in  8  SIB byte.
- r_disp  in  32  displacement, already sign-extended by decode.
- r_seg_override  in  3  override segment number (0 ES, 1 CS, 2 SS, 3 DS, 4 FS, 5 GS).
- r_seg_override_valid  in  1  override present.
- r_eax … r_edi  in  32 each  eight GPR values (index 0–7 = EAX, ECX, EDX, EBX, ESP, EBP, ESI, EDI).
- r_es, r_cs, r_ss, r_ds, r_fs, r_gs  in  16 each  segment register values.
- r_side  in  SIDE_W  sideband bundle.
- a_valid  out  1  output beat valid.
- a_ready  in  1  downstream accepts.
- a_mem  out  1  operand is memory (mod≠11).
- a_ea  out  32  effective offset.
- a_seg_num  out  3  selected segment number.
- a_seg_value  out  16  selected segment register value.
- a_side  out  SIDE_W  sideband, unchanged.

## Operation
- mod = modrm[7:6], rm = modrm[2:0]; ss = sib[7:6], idx = sib[5:3], base = sib[2:0].
- mod=11: a_mem=0, a_ea=0.
- mod≠11, rm≠100:
  - mod=00, rm=101: EA = disp (no base).
  - Otherwise, base register = rm.
- mod≠11, rm=100 (SIB form):
  - Index term = GPR[idx] << ss; idx=100 means no index.
  - Base term = GPR[base], except base=101 with mod=00, which means no base and disp32.
- Displacement is added when mod∈{01,10}, or in either no-base case. For other mod=00 forms it is treated as 0.
- EA = base + index term + disp, modulo 2^32 (carry discarded).
- Segment selection:
  - Override valid: the override number is used.
  - Otherwise SS (2) if the base register used is ESP or EBP, else DS (3).
  - mod=11 also selects DS.
  - a_seg_value is the matching register value. Numbers 6/7 give value 0.
- Buffer: 2 entries, FIFO order, each holding {mem, ea, seg_num, seg_value, side}. The address is computed combinationally at the input and stored on accept.
- Accept when r_valid & r_ready & ~flush. Dequeue when a_valid & a_ready.
- r_ready is registered and equals (count after this edge < 2).
- Simultaneous accept and dequeue with count=2 cannot occur (r_ready=0). With count=1, both happen and count stays 1.

## Timing
- Reset: count=0, a_valid=0, r_ready=1, a_mem=0, a_ea=0, a_seg_num=0, a_seg_value=0, a_side=0. Reset has priority over flush.
- Latency: a beat accepted at edge N is visible on a_* after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle while a_ready=1.
- Output stall (a_ready=0):
  - a_* hold stable.
  - The second beat is absorbed, then r_ready drops the cycle after count reaches 2.
  - r_ready rises after the first dequeue edge.
- Flush: at the edge, count=0 and a_valid=0. The offered input is dropped. r_ready=1 in the next cycle. A flush mid-stall discards both entries.
- Output data of empty entries is don't-care, but a_valid must be 0.

## Test plan
- Base+disp8: modrm=0x43 (mod01, rm=EBX), EBX=0x1000, disp=0xFFFFFFFC -> a_ea=0x00000FFC, a_seg_num=3, a_mem=1, one cycle after accept.
- SIB scaled: modrm=0x04, sib=0x88 (ss=2, idx=ECX, base=EAX), EAX=0x100, ECX=0x10 -> a_ea=0x140. Repeat with sib=0xA5 (no index, base=101, mod00), disp=0x2000 -> a_ea=0x2000, seg=DS.
- Segment default/override: modrm=0x45 (EBP+disp8), EBP=0x8000, disp=4 -> a_ea=0x8004, seg_num=2, value=SS. Same beat with override=4 -> seg_num=4, value=FS.
- Wrap and register mode: EAX=0xFFFFFFF0, disp=0x20, modrm=0x80 -> a_ea=0x00000010. modrm=0xC0 -> a_mem=0, a_ea=0.
- Backpressure: stream 4 beats with a_ready=0 -> 2 accepted, r_ready=0 after the second. Release a_ready -> all 4 emerge in order with sideband intact, no duplicates or losses.
- Flush/reset: hold 2 beats, assert flush together with r_valid=1 -> next cycle a_valid=0, r_ready=1, offered beat never appears. Repeat with reset -> all outputs 0.

Source files
------------

// File: rtl/agen_stage.sv
// Address-generation stage: computes the 32-bit effective offset and segment
// for each register-access beat, then holds it in a 2-entry skid buffer.
module agen_stage #(
  parameter int SIDE_W = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [7:0]        r_modrm,
  input  logic [7:0]        r_sib,
  input  logic [31:0]       r_disp,
  input  logic [2:0]        r_seg_override,
  input  logic              r_seg_override_valid,
  input  logic [31:0]       r_eax,
  input  logic [31:0]       r_ecx,
  input  logic [31:0]       r_edx,
  input  logic [31:0]       r_ebx,
  input  logic [31:0]       r_esp,
  input  logic [31:0]       r_ebp,
  input  logic [31:0]       r_esi,
  input  logic [31:0]       r_edi,
  input  logic [15:0]       r_es,
  input  logic [15:0]       r_cs,
  input  logic [15:0]       r_ss,
  input  logic [15:0]       r_ds,
  input  logic [15:0]       r_fs,
  input  logic [15:0]       r_gs,
  input  logic [SIDE_W-1:0] r_side,
  output logic              a_valid,
  input  logic              a_ready,
  output logic              a_mem,
  output logic [31:0]       a_ea,
  output logic [2:0]        a_seg_num,
  output logic [15:0]       a_seg_value,
  output logic [SIDE_W-1:0] a_side
);

  typedef struct packed {
    logic              mem;
    logic [31:0]       ea;
    logic [2:0]        seg_num;
    logic [15:0]       seg_value;
    logic [SIDE_W-1:0] side;
  } ent_t;

  function automatic logic [15:0] seg_lookup(input logic [2:0] n,
      input logic [15:0] es, input logic [15:0] cs, input logic [15:0] ss,
      input logic [15:0] ds, input logic [15:0] fs, input logic [15:0] gs);
    case (n)
      3'd0:    seg_lookup = es;
      3'd1:    seg_lookup = cs;
      3'd2:    seg_lookup = ss;
      3'd3:    seg_lookup = ds;
      3'd4:    seg_lookup = fs;
      3'd5:    seg_lookup = gs;
      default: seg_lookup = 16'h0000;
    endcase
  endfunction

  logic [31:0] w_gpr [8];
  assign w_gpr[0] = r_eax;
  assign w_gpr[1] = r_ecx;
  assign w_gpr[2] = r_edx;
  assign w_gpr[3] = r_ebx;
  assign w_gpr[4] = r_esp;
  assign w_gpr[5] = r_ebp;
  assign w_gpr[6] = r_esi;
  assign w_gpr[7] = r_edi;

  // Stage p0: combinational address computation on the incoming beat
  logic [1:0]  w_mod_p0, w_ss_p0;
  logic [2:0]  w_rm_p0, w_idx_p0, w_base_p0, w_breg_p0, w_seg_p0;
  logic        w_sib_p0, w_nobase_p0;
  logic [31:0] w_bterm_p0, w_iterm_p0, w_dterm_p0;
  ent_t        w_ent_p0;

  always_comb begin
    w_mod_p0    = r_modrm[7:6];
    w_rm_p0     = r_modrm[2:0];
    w_ss_p0     = r_sib[7:6];
    w_idx_p0    = r_sib[5:3];
    w_base_p0   = r_sib[2:0];
    w_sib_p0    = (w_rm_p0 == 3'd4);
    w_breg_p0   = w_sib_p0 ? w_base_p0 : w_rm_p0;
    // Both no-base encodings use register number 5 with mod=00 and carry disp32
    w_nobase_p0 = (w_mod_p0 == 2'b00) && (w_breg_p0 == 3'd5);
    w_bterm_p0  = w_nobase_p0 ? 32'h0 : w_gpr[w_breg_p0];
    w_iterm_p0  = (w_sib_p0 && (w_idx_p0 != 3'd4)) ? (w_gpr[w_idx_p0] << w_ss_p0) : 32'h0;
    w_dterm_p0  = ((w_mod_p0 == 2'b01) || (w_mod_p0 == 2'b10) || w_nobase_p0) ? r_disp : 32'h0;

    if (r_seg_override_valid)
      w_seg_p0 = r_seg_override;
    else if ((w_mod_p0 != 2'b11) && !w_nobase_p0 && ((w_breg_p0 == 3'd4) || (w_breg_p0 == 3'd5)))
      w_seg_p0 = 3'd2;
    else
      w_seg_p0 = 3'd3;

    w_ent_p0.mem       = (w_mod_p0 != 2'b11);
    w_ent_p0.ea        = (w_mod_p0 == 2'b11) ? 32'h0 : (w_bterm_p0 + w_iterm_p0 + w_dterm_p0);
    w_ent_p0.seg_num   = w_seg_p0;
    w_ent_p0.seg_value = seg_lookup(w_seg_p0, r_es, r_cs, r_ss, r_ds, r_fs, r_gs);
    w_ent_p0.side      = r_side;
  end

  // Stage p1: 2-entry buffer, head pointer plus occupancy count
  ent_t       r_ent_p1 [2];
  logic       r_head;
  logic [1:0] r_cnt;
  logic       r_rdy;
  logic       w_acc, w_deq, w_tail;
  logic [1:0] w_cnt_nxt;
  ent_t       w_out_p1;

  assign w_acc     = r_valid & r_rdy & ~flush;
  assign w_deq     = (r_cnt != 2'd0) & a_ready;
  assign w_tail    = r_head ^ r_cnt[0];
  assign w_cnt_nxt = r_cnt + {1'b0, w_acc} - {1'b0, w_deq};

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_cnt  <= 2'd0;
      r_head <= 1'b0;
      r_rdy  <= 1'b1;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_rdy <= (w_cnt_nxt < 2'd2);
      if (w_deq)
        r_head <= ~r_head;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc)
      r_ent_p1[w_tail] <= w_ent_p0;
  end

  // Empty buffer presents all-zero outputs so reset state needs no data reset
  assign a_valid     = (r_cnt != 2'd0);
  assign w_out_p1    = a_valid ? r_ent_p1[r_head] : '0;
  assign r_ready     = r_rdy;
  assign a_mem       = w_out_p1.mem;
  assign a_ea        = w_out_p1.ea;
  assign a_seg_num   = w_out_p1.seg_num;
  assign a_seg_value = w_out_p1.seg_value;
  assign a_side      = w_out_p1.side;

endmodule

// File: tb/tb_agen_stage.sv
// Scoreboard bench for agen_stage: directed beats with hand-computed addresses,
// backpressure, flush and reset.
module tb_agen_stage;
  localparam int SIDE_W = 512;

  logic              clk = 1'b0;
  logic              reset, flush, r_valid, r_ready;
  logic [7:0]        r_modrm, r_sib;
  logic [31:0]       r_disp;
  logic [2:0]        r_seg_override;
  logic              r_seg_override_valid;
  logic [31:0]       gpr [8];
  logic [15:0]       r_es, r_cs, r_ss, r_ds, r_fs, r_gs;
  logic [SIDE_W-1:0] r_side;
  logic              a_valid, a_ready, a_mem;
  logic [31:0]       a_ea;
  logic [2:0]        a_seg_num;
  logic [15:0]       a_seg_value;
  logic [SIDE_W-1:0] a_side;

  typedef struct packed {
    logic              mem;
    logic [31:0]       ea;
    logic [2:0]        sn;
    logic [15:0]       sv;
    logic [SIDE_W-1:0] side;
  } exp_t;

  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  agen_stage #(.SIDE_W(SIDE_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_modrm(r_modrm), .r_sib(r_sib), .r_disp(r_disp),
    .r_seg_override(r_seg_override), .r_seg_override_valid(r_seg_override_valid),
    .r_eax(gpr[0]), .r_ecx(gpr[1]), .r_edx(gpr[2]), .r_ebx(gpr[3]),
    .r_esp(gpr[4]), .r_ebp(gpr[5]), .r_esi(gpr[6]), .r_edi(gpr[7]),
    .r_es(r_es), .r_cs(r_cs), .r_ss(r_ss), .r_ds(r_ds), .r_fs(r_fs), .r_gs(r_gs),
    .r_side(r_side),
    .a_valid(a_valid), .a_ready(a_ready), .a_mem(a_mem), .a_ea(a_ea),
    .a_seg_num(a_seg_num), .a_seg_value(a_seg_value), .a_side(a_side)
  );

  function automatic logic [SIDE_W-1:0] mk_side(input int k);
    mk_side = {16{32'hC0DE0000 | 32'(k)}};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: every handshake on the output pops and compares one expected beat
  always begin
    exp_t got, want;
    @(negedge clk);
    if (!reset && !flush && a_valid && a_ready) begin
      got = '{mem: a_mem, ea: a_ea, sn: a_seg_num, sv: a_seg_value, side: a_side};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat got ea=%0h side=%0h", got.ea, got.side[31:0]);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL beat got mem=%0b ea=%0h seg=%0d val=%0h side=%0h want mem=%0b ea=%0h seg=%0d val=%0h side=%0h",
                   got.mem, got.ea, got.sn, got.sv, got.side[31:0],
                   want.mem, want.ea, want.sn, want.sv, want.side[31:0]);
        end
      end
    end
  end

  // Called at posedge+1; offers one beat until accepted, pushing its expectation
  task automatic send(input logic [7:0] modrm, input logic [7:0] sib, input logic [31:0] disp,
                      input logic ovv, input logic [2:0] ov, input int k,
                      input logic emem, input logic [31:0] eea, input logic [2:0] esn,
                      input logic [15:0] esv);
    bit done = 0;
    r_valid = 1'b1; r_modrm = modrm; r_sib = sib; r_disp = disp;
    r_seg_override_valid = ovv; r_seg_override = ov; r_side = mk_side(k);
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (r_ready) begin
        exp_q.push_back('{mem: emem, ea: eea, sn: esn, sv: esv, side: mk_side(k)});
        done = 1;
      end
      @(posedge clk); #1;
    end
    r_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout beat=%0d got=not_accepted want=accepted", k);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d want=0 pending", exp_q.size());
    end
  endtask

  task automatic set_gprs();
    gpr[0] = 32'h100;  gpr[1] = 32'h10;   gpr[2] = 32'h20; gpr[3] = 32'h1000;
    gpr[4] = 32'h7000; gpr[5] = 32'h8000; gpr[6] = 32'h30; gpr[7] = 32'h40;
  endtask

  task automatic check_zero_out(input string tag);
    check({tag, "_a_valid"}, 64'(a_valid), 64'd0);
    check({tag, "_r_ready"}, 64'(r_ready), 64'd1);
    check({tag, "_outs_zero"}, 64'({a_mem, a_ea, a_seg_num, a_seg_value, |a_side}), 64'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; r_valid = 1'b0; a_ready = 1'b1;
    r_modrm = '0; r_sib = '0; r_disp = '0; r_seg_override = '0;
    r_seg_override_valid = 1'b0; r_side = '0;
    r_es = 16'h1111; r_cs = 16'h2222; r_ss = 16'h3333;
    r_ds = 16'h4444; r_fs = 16'h5555; r_gs = 16'h6666;
    set_gprs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_zero_out("reset0");
    @(posedge clk); #1;

    // Base+disp8 with one-cycle latency
    send(8'h43, 8'h00, 32'hFFFFFFFC, 0, 0, 1, 1, 32'h00000FFC, 3'd3, 16'h4444);
    @(negedge clk);
    check("latency_valid", 64'(a_valid), 64'd1);
    check("latency_ea", 64'(a_ea), 64'h0FFC);
    @(posedge clk); #1;

    send(8'h04, 8'h88, 32'h00000055, 0, 0, 2, 1, 32'h140, 3'd3, 16'h4444);
    send(8'h04, 8'hA5, 32'h00002000, 0, 0, 3, 1, 32'h2000, 3'd3, 16'h4444);
    send(8'h45, 8'h00, 32'h4, 0, 0, 4, 1, 32'h8004, 3'd2, 16'h3333);
    send(8'h45, 8'h00, 32'h4, 1, 3'd4, 5, 1, 32'h8004, 3'd4, 16'h5555);
    send(8'h45, 8'h00, 32'h4, 1, 3'd6, 6, 1, 32'h8004, 3'd6, 16'h0000);
    send(8'h05, 8'h00, 32'h1234, 0, 0, 7, 1, 32'h1234, 3'd3, 16'h4444);
    send(8'h04, 8'h24, 32'h0, 0, 0, 8, 1, 32'h7000, 3'd2, 16'h3333);
    gpr[0] = 32'hFFFFFFF0;
    send(8'h80, 8'h00, 32'h20, 0, 0, 9, 1, 32'h10, 3'd3, 16'h4444);
    send(8'hC0, 8'h00, 32'h20, 0, 0, 10, 0, 32'h0, 3'd3, 16'h4444);
    set_gprs();
    drain();

    // Backpressure: two absorbed, then stall, then release
    a_ready = 1'b0;
    send(8'h43, 8'h00, 32'h1, 0, 0, 11, 1, 32'h1001, 3'd3, 16'h4444);
    send(8'h43, 8'h00, 32'h2, 0, 0, 12, 1, 32'h1002, 3'd3, 16'h4444);
    @(negedge clk);
    check("bp_r_ready_low", 64'(r_ready), 64'd0);
    check("bp_head_hold", 64'(a_ea), 64'h1001);
    @(posedge clk); #1;
    a_ready = 1'b1;
    send(8'h43, 8'h00, 32'h3, 0, 0, 13, 1, 32'h1003, 3'd3, 16'h4444);
    send(8'h43, 8'h00, 32'h4, 0, 0, 14, 1, 32'h1004, 3'd3, 16'h4444);
    drain();

    // Flush with a beat offered in the same cycle
    a_ready = 1'b0;
    send(8'h43, 8'h00, 32'h5, 0, 0, 15, 1, 32'h1005, 3'd3, 16'h4444);
    send(8'h43, 8'h00, 32'h6, 0, 0, 16, 1, 32'h1006, 3'd3, 16'h4444);
    r_valid = 1'b1; r_modrm = 8'h43; r_disp = 32'h77; r_side = mk_side(99); flush = 1'b1;
    @(negedge clk); exp_q.delete();
    @(posedge clk); #1 flush = 1'b0; r_valid = 1'b0;
    @(negedge clk);
    check("flush_a_valid", 64'(a_valid), 64'd0);
    check("flush_r_ready", 64'(r_ready), 64'd1);
    @(posedge clk); #1 a_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset while holding two beats, with flush and an offered beat
    a_ready = 1'b0;
    send(8'h43, 8'h00, 32'h8, 0, 0, 17, 1, 32'h1008, 3'd3, 16'h4444);
    send(8'h43, 8'h00, 32'h9, 0, 0, 18, 1, 32'h1009, 3'd3, 16'h4444);
    r_valid = 1'b1; r_side = mk_side(98); reset = 1'b1; flush = 1'b1;
    @(negedge clk); exp_q.delete();
    @(posedge clk); #1 reset = 1'b0; flush = 1'b0; r_valid = 1'b0;
    @(negedge clk);
    check_zero_out("reset1");
    @(posedge clk); #1 a_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
